buffer_loader: RTL

Serial host for the pattern-buffer bank: it fills one selected 32-byte pattern buffer over the `sin`/`ssel`/`saddr` serial port while capturing the previous contents returned on `sout`. It sits between the configuration/sequence control logic (parallel byte stream in, readback bytes out) and the buffer bank. One load always shifts exactly `BUFFER_SIZE` bytes, so the addressed buffer is completely rewritten. The block runs on the same `sclk` as the buffers, so every bit it drives is shifted into the addressed buffer on the next `sclk` rising edge.

---
 rtl/buffers_pkg.sv | 23 ++
 rtl/serial_byte_shifter.sv | 68 ++++++
 rtl/buffer_loader.sv | 108 ++++++++++
 3 files changed

// File: rtl/buffers_pkg.sv
`default_nettype none
// ============================================================================
// Module      : buffers_pkg
// Description : Shared sizing constants and loader state type for the
//               pattern-buffer bank and its serial loader.
// Revision    : 1.0 - initial release
// ============================================================================
package buffers_pkg;

    localparam int BUFFER_SIZE  = 32;
    localparam int BUFFER_WIDTH = 8;
    localparam int NO_BUFS      = 8;
    localparam int ADDR_W       = $clog2(NO_BUFS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_byte_shifter.sv
`default_nettype none
// ============================================================================
// Module      : serial_byte_shifter
// Description : Byte-wide PISO (tx, MSB first) and SIPO (rx, MSB first) with
//               a shared bit counter; emits each completed rx byte as a strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_byte_shifter #(
    parameter int WIDTH = buffers_pkg::BUFFER_WIDTH
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             sout,
    output logic             sin,
    output logic             last_bit,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid
);
    import buffers_pkg::*;

    localparam int                c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0]   r_tx;
    logic [WIDTH-1:0]   r_rx;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0]   r_rx_data;
    logic               r_rx_valid;
    logic [WIDTH-1:0]   w_rx_next;

    assign w_rx_next = {r_rx[WIDTH-2:0], sout};

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_tx       <= '0;
            r_rx       <= '0;
            r_bit_cnt  <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (shift_en) begin
                r_tx      <= {r_tx[WIDTH-2:0], 1'b0};
                r_rx      <= w_rx_next;
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (last_bit) begin
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                end
            end
            // A reload on the final bit overrides the shift so the next byte starts gaplessly.
            if (load) begin
                r_tx      <= load_data;
                r_bit_cnt <= '0;
            end
        end
    end

    assign sin      = r_tx[WIDTH-1];
    assign last_bit = (r_bit_cnt == c_LAST);
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule
`default_nettype wire

// File: rtl/buffer_loader.sv
`default_nettype none
// ============================================================================
// Module      : buffer_loader
// Description : Serial host that rewrites one whole pattern buffer over the
//               sin/ssel/saddr port while returning its old contents.
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_loader #(
    parameter int BUFFER_SIZE  = buffers_pkg::BUFFER_SIZE,
    parameter int BUFFER_WIDTH = buffers_pkg::BUFFER_WIDTH,
    parameter int NO_BUFS      = buffers_pkg::NO_BUFS,
    parameter int ADDR_W       = $clog2(NO_BUFS)
) (
    input  logic                    sclk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [BUFFER_WIDTH-1:0] wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [BUFFER_WIDTH-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    ssel,
    output logic [ADDR_W-1:0]       saddr,
    output logic                    sin,
    input  logic                    sout
);
    import buffers_pkg::*;

    localparam int                   c_BYTE_W    = $clog2(BUFFER_SIZE);
    localparam logic [c_BYTE_W-1:0] c_LAST_BYTE = c_BYTE_W'(BUFFER_SIZE - 1);

    loader_state_t       r_state;
    logic [ADDR_W-1:0]   r_saddr;
    logic [c_BYTE_W-1:0] r_byte_cnt;

    logic w_shift_en;
    logic w_last_bit;
    logic w_last_byte;
    logic w_load;

    assign w_shift_en  = (r_state == SHIFT);
    assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);
    // Ready is decoded from registered state only, never from wr_valid.
    assign wr_ready    = (r_state == FETCH) || (w_shift_en && w_last_bit && !w_last_byte);
    assign w_load      = wr_valid && wr_ready;

    assign ssel  = w_shift_en;
    assign busy  = (r_state == FETCH) || (r_state == SHIFT);
    assign done  = (r_state == DONE);
    assign saddr = r_saddr;

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_saddr    <= '0;
            r_byte_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_saddr    <= addr;
                        r_byte_cnt <= '0;
                        r_state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (wr_valid) begin
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_last_bit) begin
                        if (w_last_byte) begin
                            r_state <= DONE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            if (!wr_valid) begin
                                r_state <= FETCH;
                            end
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    serial_byte_shifter #(
        .WIDTH (BUFFER_WIDTH)
    ) u_shifter (
        .sclk      (sclk),
        .rst       (rst),
        .load      (w_load),
        .load_data (wr_data),
        .shift_en  (w_shift_en),
        .sout      (sout),
        .sin       (sin),
        .last_bit  (w_last_bit),
        .rx_data   (rd_data),
        .rx_valid  (rd_valid)
    );

endmodule
`default_nettype wire
